// File: rtl/hazard_fwd_ctrl_if.sv
// Hazard/forwarding controller bus.
// Groups every non-clock/reset signal exchanged between the pipeline and
// hazard_fwd_ctrl.
//   master : pipeline side; drives the decode instruction, older-stage
//            destination info and redirect sources, and receives the
//            forward selects, stall/flush, intr_ack, busy and perf counters.
//   slave  : controller side, the mirror image of master.
interface hazard_fwd_ctrl_if #(
    parameter int NUM_FWD_STAGES = 2,
    parameter int REG_AW         = 5,
    parameter int PERF_W         = 16,
    parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
);
    logic [31:0]                      instr_d;
    logic [NUM_FWD_STAGES*REG_AW-1:0] fwd_rd;
    logic [NUM_FWD_STAGES-1:0]        fwd_we;
    logic [NUM_FWD_STAGES-1:0]        fwd_is_load;
    logic                             br_taken;
    logic                             is_mret;
    logic                             intr_req;
    logic [SEL_W-1:0]                 fwd_a;
    logic [SEL_W-1:0]                 fwd_b;
    logic                             stall;
    logic                             flush;
    logic                             intr_ack;
    logic                             busy;
    logic [PERF_W-1:0]                stall_cnt;
    logic [PERF_W-1:0]                flush_cnt;

    modport master (
        output instr_d, fwd_rd, fwd_we, fwd_is_load, br_taken, is_mret, intr_req,
        input  fwd_a, fwd_b, stall, flush, intr_ack, busy, stall_cnt, flush_cnt
    );

    modport slave (
        input  instr_d, fwd_rd, fwd_we, fwd_is_load, br_taken, is_mret, intr_req,
        output fwd_a, fwd_b, stall, flush, intr_ack, busy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding, load-use stall and redirect-flush controller for the RV32 core.
// Ports:
//   clk  - core clock
//   rst  - asynchronous, active-high reset
//   bus  - hazard_fwd_ctrl_if.slave:
//          in : instr_d, fwd_rd, fwd_we, fwd_is_load, br_taken, is_mret, intr_req
//          out: fwd_a, fwd_b (0 = regfile, k+1 = older stage k), stall, flush,
//               intr_ack, busy, stall_cnt, flush_cnt (saturating perf counters)
module hazard_fwd_ctrl #(
    parameter int NUM_FWD_STAGES = 2,
    parameter int REG_AW         = 5,
    parameter int FLUSH_CYCLES   = 1,
    parameter int PERF_W         = 16,
    parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    hazard_fwd_ctrl_if.slave bus
);
    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [3:0]        fcnt_q, fcnt_d;
    logic              intr_pend_q;
    logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

    logic [REG_AW-1:0] rs1, rs2;
    logic [SEL_W-1:0]  sel_a, sel_b;
    logic              load_a, load_b;
    logic              intr_live, evt, intr_evt, stall_int;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign rs1 = REG_AW'(bus.instr_d[19:15]);
    assign rs2 = REG_AW'(bus.instr_d[24:20]);

    // Opcode/funct bits are irrelevant to hazard detection.
    logic unused_instr;
    assign unused_instr = &{1'b0, bus.instr_d[31:25], bus.instr_d[14:0]};

    // Scan from the oldest stage down so the youngest match overwrites.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        load_a = 1'b0;
        load_b = 1'b0;
        for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
            if (bus.fwd_we[k] && (bus.fwd_rd[k*REG_AW +: REG_AW] != '0)) begin
                if (bus.fwd_rd[k*REG_AW +: REG_AW] == rs1) begin
                    sel_a  = SEL_W'(k + 1);
                    load_a = bus.fwd_is_load[k];
                end
                if (bus.fwd_rd[k*REG_AW +: REG_AW] == rs2) begin
                    sel_b  = SEL_W'(k + 1);
                    load_b = bus.fwd_is_load[k];
                end
            end
        end
    end

    // A latched request stays serviceable until acknowledged; the latch
    // itself is dropped when the requester withdraws.
    assign intr_live = bus.intr_req | intr_pend_q;
    assign evt       = (state_q == IDLE) && (intr_live || bus.is_mret || bus.br_taken);
    assign intr_evt  = (state_q == IDLE) && intr_live;
    assign stall_int = !rst && (state_q == IDLE) && !evt && (load_a || load_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fcnt_q      <= '0;
            intr_pend_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            intr_pend_q <= bus.intr_req && !intr_evt;
            if (stall_int)
                stall_cnt_q <= sat_inc(stall_cnt_q);
            if (evt)
                flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (evt && (FLUSH_CYCLES > 1)) begin
                    state_d = FLUSH;
                    fcnt_d  = 4'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (fcnt_q <= 4'd1) begin
                    state_d = IDLE;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d  = fcnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A redirect or flush sequence kills the decode instruction, so its
    // stall and forward selects are meaningless and driven to 0.
    always_comb begin
        bus.fwd_a    = '0;
        bus.fwd_b    = '0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.intr_ack = 1'b0;
        bus.busy     = 1'b0;
        if (!rst) begin
            if (state_q == IDLE && !evt) begin
                bus.fwd_a = load_a ? '0 : sel_a;
                bus.fwd_b = load_b ? '0 : sel_b;
            end
            bus.stall    = stall_int;
            bus.flush    = evt || (state_q == FLUSH);
            bus.intr_ack = intr_evt;
            bus.busy     = (state_q == FLUSH);
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Parametrised forwarding, stall and flush controller for the pipelined RV32 core with CSRs.
- Resolves RAW hazards against up to NUM_FWD_STAGES older pipeline stages, inserts load-use stalls, and sequences multi-cycle flushes for taken branches, mret and interrupts.
- Latches interrupt requests until they are accepted.
- Keeps saturating stall and flush event counters for performance CSRs.

Parameters:
- NUM_FWD_STAGES, 2: number of older stages that can forward. Index 0 is the youngest (EX/MEM), 1 is next (MEM/WB). Legal range 1..4.
- REG_AW, 5: register address width.
- FLUSH_CYCLES, 1: cycles flush stays high per redirect event. Legal range 1..8.
- PERF_W, 16: width of the performance counters.
- SEL_W, $clog2(NUM_FWD_STAGES+1): width of each forward select.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- instr_d  in  32  instruction consuming operands; rs1=[19:15], rs2=[24:20]
- fwd_rd  in  NUM_FWD_STAGES*REG_AW  destination reg per older stage; slice k = stage k
- fwd_we  in  NUM_FWD_STAGES  register-write enable per older stage
- fwd_is_load  in  NUM_FWD_STAGES  stage k holds a load whose data is not yet available
- br_taken  in  1  branch or jump redirect resolved this cycle
- is_mret  in  1  mret committing this cycle
- intr_req  in  1  interrupt request from the CSR unit (level)
- fwd_a  out  SEL_W  rs1 source: 0 = register file, k+1 = stage k
- fwd_b  out  SEL_W  rs2 source, same encoding
- stall  out  1  hold PC and the fetch/decode register; bubble into the next stage
- flush  out  1  kill the younger pipeline register(s)
- intr_ack  out  1  one-cycle pulse: interrupt accepted, CSR unit redirects to mtvec
- busy  out  1  flush sequence in progress (state FLUSH)
- stall_cnt  out  PERF_W  saturating count of stall cycles
- flush_cnt  out  PERF_W  saturating count of redirect events (not flush cycles)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, flush counter=0, intr_pend=0, stall_cnt=0, flush_cnt=0.
  - All combinational outputs are forced to 0 while rst=1.
- Forwarding (combinational):
  - Stage k matches rs1 when fwd_we[k] is set, fwd_rd[k]!=0 and fwd_rd[k]==rs1. Same rule for rs2.
  - The lowest matching k wins (youngest data), giving fwd_a=k+1; no match gives 0.
  - rs1 and rs2 are resolved independently; both may forward in the same cycle.
- Load-use: if the winning match for rs1 or rs2 is a stage with fwd_is_load set, then stall=1 and that select is 0.
- Interrupt latch: intr_pend is set on intr_req=1. It clears on the intr_ack cycle or when intr_req drops before acceptance.
- FSM states: IDLE, FLUSH.
  - IDLE, redirect event priority: intr_pend > is_mret > br_taken.
  - On an event: flush=1 in the same cycle and flush_cnt += 1. intr_ack=1 only if the event is the interrupt.
  - If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1.
  - Any event suppresses stall, fwd_a and fwd_b (all 0) that cycle; the stalled instruction is killed.
  - FLUSH: flush=1, busy=1, stall=0, fwd_a=fwd_b=0. The counter decrements each cycle; at 1 the FSM returns to IDLE.
  - FLUSH: br_taken and is_mret are ignored because they come from killed instructions. intr_req still latches into intr_pend, which is serviced on the first IDLE cycle.
- Counters:
  - stall_cnt increments on each cycle with stall=1.
  - Both counters saturate at all-ones with no wrap.
- Reset asserted mid-FLUSH aborts the sequence immediately; after release the FSM is in IDLE and flush=0.

Test Plan:
- Forward priority: instr_d rs1=5, rs2=6; stage0 rd=5 we=1; stage1 rd=5 we=1 and rd=6 we=1 (two cycles) -> fwd_a=1 (stage0 wins), fwd_b=2, stall=0. Repeat with rd=0 in every stage -> both selects 0.
- Load-use: stage0 rd=7, we=1, is_load=1; rs2=7 -> stall=1, fwd_b=0, stall_cnt +1. Next cycle the load is in stage1 -> stall=0, fwd_b=2.
- Flush length with FLUSH_CYCLES=3: br_taken one cycle -> flush high exactly 3 cycles, busy high for the last 2, flush_cnt=1. A br_taken pulse during FLUSH does not change the sequence or the count.
- Priority: intr_req, is_mret and br_taken together in IDLE -> intr_ack pulses once, flush_cnt +1 only. An intr_req raised mid-FLUSH and held -> intr_ack on the first IDLE cycle.
- Event kills stall: load-use hazard present and br_taken=1 in the same cycle -> stall=0, flush=1.
- Reset/saturation: rst asserted mid-FLUSH -> flush=0 immediately and stays 0 after release. With PERF_W=4, 20 consecutive stall cycles -> stall_cnt holds 15.
